spi_mem_loader: RTL and testbench

//  Command sequencer that owns port B of the 32-bit dual-port program/data RAM.

---
 rtl/spi_mem_loader.sv | 174 +++++++++++++++++
 tb/tb_spi_mem_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// SPI command sequencer owning RAM port B: word writes/reads, CPU halt/run, sticky error.
// Optional MEM_LOADER_CSUM_EN adds a write-data XOR checksum (0x05 reads it, 0x07 clears it).
module spi_mem_loader #(
    parameter int unsigned ADDR_LIMIT    = 1024,
    parameter bit          HALT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        we_b,
    output logic [31:0] addr_b,
    output logic [31:0] wd_b,
    input  logic [31:0] rd_b,
    output logic        cpu_halt,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, WDATA, WRITE, RD_WAIT, RD_CAP, TX, DRAIN
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] sh;
    logic [31:0] tx_word;
    logic        is_read;

    logic        addr_oor;
    logic [31:0] rx_word;
    logic [31:0] rd_word;

    assign addr_oor = (addr_b >= 32'(ADDR_LIMIT));
    assign rx_word  = {sh[23:0], rx_byte};
    assign rd_word  = addr_oor ? 32'd0 : rd_b;

`ifdef MEM_LOADER_CSUM_EN
    logic [31:0] csum;
    logic        tx_csum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            sh       <= 32'd0;
            tx_word  <= 32'd0;
            is_read  <= 1'b0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'd0;
            we_b     <= 1'b0;
            addr_b   <= 32'd0;
            wd_b     <= 32'd0;
            cpu_halt <= HALT_ON_RESET;
            busy     <= 1'b0;
            err      <= 1'b0;
`ifdef MEM_LOADER_CSUM_EN
            csum     <= 32'd0;
            tx_csum  <= 1'b0;
`endif
        end else begin
            we_b <= 1'b0;
            // The FSM leaves IDLE exactly when cs is seen active, so busy tracks cs by one cycle.
            busy <= cs_active;
            if (!cs_active) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, CMD: begin
                        state <= CMD;
                        if (rx_valid) begin
                            cnt <= 2'd0;
                            case (rx_byte)
                                8'h01: begin is_read <= 1'b0; state <= ADDR; end
                                8'h02: begin
                                    is_read <= 1'b1;
                                    state   <= ADDR;
`ifdef MEM_LOADER_CSUM_EN
                                    tx_csum <= 1'b0;
`endif
                                end
                                8'h03: begin cpu_halt <= 1'b1; state <= DRAIN; end
                                8'h04: begin cpu_halt <= 1'b0; state <= DRAIN; end
                                8'h06: begin err <= 1'b0; state <= DRAIN; end
`ifdef MEM_LOADER_CSUM_EN
                                8'h05: begin
                                    tx_csum  <= 1'b1;
                                    tx_byte  <= csum[31:24];
                                    tx_word  <= {csum[23:0], 8'h00};
                                    tx_valid <= 1'b1;
                                    state    <= TX;
                                end
                                8'h07: begin csum <= 32'd0; state <= DRAIN; end
`endif
                                default: begin err <= 1'b1; state <= DRAIN; end
                            endcase
                        end
                    end
                    ADDR: if (rx_valid) begin
                        sh  <= rx_word;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            addr_b <= {rx_word[31:2], 2'b00};
                            state  <= is_read ? RD_WAIT : WDATA;
                        end
                    end
                    WDATA: if (rx_valid) begin
                        sh  <= rx_word;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            wd_b  <= rx_word;
                            state <= WRITE;
                            if (addr_oor) begin
                                err <= 1'b1;
                            end else begin
                                we_b <= 1'b1;
`ifdef MEM_LOADER_CSUM_EN
                                csum <= csum ^ rx_word;
`endif
                            end
                        end
                    end
                    // A byte landing here is the first of the next burst word.
                    WRITE: begin
                        addr_b <= addr_b + 32'd4;
                        state  <= WDATA;
                        if (rx_valid) begin
                            sh  <= rx_word;
                            cnt <= cnt + 2'd1;
                        end
                    end
                    RD_WAIT: state <= RD_CAP;
                    RD_CAP: begin
                        if (addr_oor) err <= 1'b1;
                        tx_byte  <= rd_word[31:24];
                        tx_word  <= {rd_word[23:0], 8'h00};
                        tx_valid <= 1'b1;
                        cnt      <= 2'd0;
                        state    <= TX;
                    end
                    TX: if (tx_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            tx_valid <= 1'b0;
`ifdef MEM_LOADER_CSUM_EN
                            if (tx_csum) begin
                                state <= DRAIN;
                            end else begin
                                addr_b <= addr_b + 32'd4;
                                state  <= RD_WAIT;
                            end
`else
                            addr_b <= addr_b + 32'd4;
                            state  <= RD_WAIT;
`endif
                        end else begin
                            tx_byte <= tx_word[31:24];
                            tx_word <= {tx_word[23:0], 8'h00};
                        end
                    end
                    DRAIN: state <= DRAIN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: frame-level memory/err/halt model, registered RAM on port B,
// per-cycle comparison of write pulses and transmitted bytes against model queues.
module tb_spi_mem_loader;

    localparam logic [31:0] LIMIT = 32'd1024;

    logic        clk = 1'b0;
    logic        rst_n, cs_active, rx_valid, tx_ready;
    logic [7:0]  rx_byte;
    logic        tx_valid, we_b, cpu_halt, busy, err;
    logic [7:0]  tx_byte;
    logic [31:0] addr_b, wd_b, rd_b;

    always #5 clk = ~clk;

    spi_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
        .we_b(we_b), .addr_b(addr_b), .wd_b(wd_b), .rd_b(rd_b),
        .cpu_halt(cpu_halt), .busy(busy), .err(err)
    );

    // Registered-read RAM on port B
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (we_b) ram[addr_b[9:2]] <= wd_b;
        rd_b <= ram[addr_b[9:2]];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Model state
    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] mdl_mem [0:255];
    bit          mdl_err;
    bit          mdl_halt;
    logic [31:0] mdl_csum;

    // Observations
    wr_t         e;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;
    logic [31:0] tx_last = 32'd0;
    bit          hold_pend = 1'b0;
    logic [7:0]  hold_byte = 8'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend && cs_active) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_byte", 32'(tx_byte), 32'(hold_byte));
            end
            hold_pend = tx_valid && !tx_ready && cs_active;
            hold_byte = tx_byte;
            if (we_b) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_we", 32'(we_b), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", addr_b, e.a);
                    chk("wr_data", wd_b, e.d);
                end
                last_wr_addr = addr_b;
                last_wr_data = wd_b;
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk("unexpected_tx", 32'(tx_valid), 32'd0);
                else chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
                tx_last = {tx_last[23:0], tx_byte};
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic begin_frame();
        cs_active = 1'b1;
        tick();
        tick();
        chk("busy_frame", 32'(busy), 32'd1);
    endtask

    task automatic end_frame();
        cs_active = 1'b0;
        tick();
        tick();
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic send_addr(input logic [31:0] addr);
        for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8]);
    endtask

    task automatic collect_tx(input int n, input int stall);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!tx_valid && t < 64) begin
                tick();
                t++;
            end
            if (!tx_valid) begin
                chk("tx_timeout", 32'(tx_valid), 32'd1);
                break;
            end
            for (int s = 0; s < stall; s++) begin
                rx_valid = (s == 0);
                rx_byte  = 8'h5A;
                tick();
            end
            rx_valid = 1'b0;
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
    endtask

    task automatic write_frame(input logic [31:0] addr, input logic [63:0] data, input int nbytes);
        logic [31:0] a;
        logic [31:0] w;
        a = {addr[31:2], 2'b00};
        for (int i = 0; i + 4 <= nbytes; i += 4) begin
            w = data[8*(nbytes-i)-1 -: 32];
            if (a < LIMIT) begin
                exp_wr.push_back({a, w});
                mdl_mem[a[9:2]] = w;
                mdl_csum ^= w;
            end else begin
                mdl_err = 1'b1;
            end
            a += 32'd4;
        end
        begin_frame();
        send_byte(8'h01);
        send_addr(addr);
        for (int i = 0; i < nbytes; i++) send_byte(data[8*(nbytes-i)-1 -: 8]);
        end_frame();
        chk("wr_all_seen", 32'(exp_wr.size()), 32'd0);
        chk("err_after_wr", 32'(err), 32'(mdl_err));
    endtask

    task automatic read_frame(input logic [31:0] addr, input int nwords, input int stall);
        logic [31:0] a;
        logic [31:0] w;
        a = {addr[31:2], 2'b00};
        for (int n = 0; n < nwords; n++) begin
            if (a < LIMIT) begin
                w = mdl_mem[a[9:2]];
            end else begin
                w = 32'd0;
                mdl_err = 1'b1;
            end
            for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
            a += 32'd4;
        end
        begin_frame();
        send_byte(8'h02);
        send_addr(addr);
        collect_tx(4 * nwords, stall);
        end_frame();
        chk("tx_all_seen", 32'(exp_tx.size()), 32'd0);
        chk("err_after_rd", 32'(err), 32'(mdl_err));
    endtask

    task automatic ctrl_frame(input logic [7:0] cmd);
        case (cmd)
            8'h03: mdl_halt = 1'b1;
            8'h04: mdl_halt = 1'b0;
            8'h06: mdl_err = 1'b0;
`ifdef MEM_LOADER_CSUM_EN
            8'h07: mdl_csum = 32'd0;
`endif
            default: mdl_err = 1'b1;
        endcase
        begin_frame();
        send_byte(cmd);
        send_byte(8'h01);
        end_frame();
        chk("err_after_ctrl", 32'(err), 32'(mdl_err));
        chk("halt_after_ctrl", 32'(cpu_halt), 32'(mdl_halt));
    endtask

`ifdef MEM_LOADER_CSUM_EN
    task automatic csum_frame();
        for (int b = 3; b >= 0; b--) exp_tx.push_back(mdl_csum[8*b +: 8]);
        begin_frame();
        send_byte(8'h05);
        collect_tx(4, 1);
        end_frame();
        chk("csum_all_seen", 32'(exp_tx.size()), 32'd0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'd0; tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mdl_mem[i] = 32'd0;
            ram[i] = 32'd0;
        end
        mdl_err = 1'b0; mdl_halt = 1'b1; mdl_csum = 32'd0;
        repeat (3) tick();
        chk("rst_we_b", 32'(we_b), 32'd0);
        chk("rst_addr_b", addr_b, 32'd0);
        chk("rst_wd_b", wd_b, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single word write
        write_frame(32'h10, 64'hDEAD_BEEF, 4);
        chk("t1_addr", last_wr_addr, 32'h10);
        chk("t1_data", last_wr_data, 32'hDEAD_BEEF);

        // Read back with a 3-cycle tx_ready stall per byte
        read_frame(32'h10, 1, 3);
        chk("t3_word", tx_last, 32'hDEAD_BEEF);

        // Two-word burst write
        write_frame(32'h10, 64'h1112_1314_1516_1718, 8);
        chk("t2_addr", last_wr_addr, 32'h14);
        chk("t2_data", last_wr_data, 32'h1516_1718);
        chk("t2_model", mdl_mem[4], 32'h1112_1314);

        // Unaligned address is forced to a word boundary
        write_frame(32'h23, 64'hCAFE_F00D, 4);
        chk("align_addr", last_wr_addr, 32'h20);

        // Partial word then cs drop coinciding with the completing byte: nothing written
        begin_frame();
        send_byte(8'h01);
        send_addr(32'h20);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        cs_active = 1'b0;
        rx_byte = 8'hDD;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("t4_idle_next", 32'(busy), 32'd0);
        tick();
        tick();
        read_frame(32'h10, 2, 0);
        chk("t4_burst_rd", tx_last, 32'h1516_1718);
        read_frame(32'h20, 1, 1);
        chk("t4_untouched", tx_last, 32'hCAFE_F00D);

        // Out-of-range handling and error clear
        write_frame(32'h400, 64'h0102_0304, 4);
        chk("oor_err", 32'(err), 32'd1);
        ctrl_frame(8'h06);
        write_frame(32'h3FC, 64'hA1A2_A3A4_B1B2_B3B4, 8);
        chk("edge_wr_addr", last_wr_addr, 32'h3FC);
        ctrl_frame(8'h06);
        read_frame(32'h3FC, 2, 0);
        chk("oor_rd_zero", tx_last, 32'd0);
        ctrl_frame(8'h06);
        ctrl_frame(8'h09);
        chk("unknown_err", 32'(err), 32'd1);

`ifdef MEM_LOADER_CSUM_EN
        csum_frame();
        ctrl_frame(8'h07);
        csum_frame();
        chk("csum_cleared", tx_last, 32'd0);
`else
        ctrl_frame(8'h06);
        ctrl_frame(8'h05);
        ctrl_frame(8'h06);
        ctrl_frame(8'h07);
`endif

        // Halt/run control and reset restoring halt
        ctrl_frame(8'h04);
        ctrl_frame(8'h03);
        ctrl_frame(8'h04);
        chk("run_state", 32'(cpu_halt), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rst2_cpu_halt", 32'(cpu_halt), 32'd1);
        chk("rst2_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        mdl_halt = 1'b1;
        mdl_err = 1'b0;
        mdl_csum = 32'd0;
        tick();
        read_frame(32'h14, 1, 0);
        chk("post_rst_rd", tx_last, 32'h1516_1718);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
